// File: rtl/game_pkg.sv
// Shared types and constants for the board display path: animator state
// encoding, controller event codes and small position helpers.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        DONE,
        SETTLE,
        EVENT_MOVE,
        EVENT_DWELL
    } anim_state_t;

    localparam logic [3:0] EV_NONE   = 4'd1;
    localparam logic [3:0] EV_BACK   = 4'd3;
    localparam logic [3:0] EV_WIN    = 4'd10;
    localparam logic [3:0] BOARD_MAX = 4'd10;

    function automatic logic [3:0] clamp_pos(input logic [3:0] pos, input logic [3:0] max_pos);
        return (pos > max_pos) ? max_pos : pos;
    endfunction

    // One square toward the target; holds when already there, so it never wraps.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 4'd1;
        end else if (cur > tgt) begin
            nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/anim_tick_timer.sv
// Free-running period counter with synchronous clear; tc pulses on the last
// cycle of each period and the count wraps to zero on that same edge.
module anim_tick_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = enable && (count == period - WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/board_token_animator.sv
// Walks each player's displayed token one square per step period toward the
// controller's committed square and reports move/event completion with turn_done.
module board_token_animator
    import game_pkg::*;
#(
    parameter int unsigned STEP_CYC    = 25_000_000,
    parameter int unsigned EVENT_DWELL = 100_000_000,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned MAX_POS     = BOARD_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pos_valid,
    input  logic       turn,
    input  logic [3:0] p1_pos,
    input  logic [3:0] p2_pos,
    input  logic [3:0] event_flag,
    output logic       turn_done,
    output logic [3:0] disp_p1,
    output logic [3:0] disp_p2,
    output logic       active_player,
    output logic       anim_busy,
    output logic       step_strobe
);

    localparam logic [3:0]  MAX4     = 4'(MAX_POS);
    localparam logic [31:0] STEP_P   = 32'(STEP_CYC);
    localparam logic [31:0] DWELL_P  = 32'(EVENT_DWELL);
    localparam logic [31:0] SETTLE_P = 32'(SETTLE_CYC);

    anim_state_t state, state_d;

    logic       pos_valid_q;
    logic       rise;
    logic [3:0] tgt_p1, tgt_p2;
    logic [3:0] mover_disp, mover_tgt, step_disp;
    logic [3:0] disp_p1_d, disp_p2_d;
    logic       active_d;
    logic       turn_done_d;
    logic       step_strobe_d;

    logic        timer_clear;
    logic        timer_enable;
    logic [31:0] timer_period;
    logic        timer_tc;

    assign rise       = pos_valid & ~pos_valid_q;
    assign tgt_p1     = clamp_pos(p1_pos, MAX4);
    assign tgt_p2     = clamp_pos(p2_pos, MAX4);
    assign mover_disp = active_player ? disp_p2 : disp_p1;
    assign mover_tgt  = active_player ? tgt_p2 : tgt_p1;
    assign step_disp  = step_toward(mover_disp, mover_tgt);

    // The timer is held at zero outside the timed states, so every timed state
    // starts a fresh period; consecutive timed states rely on the wrap at tc.
    assign timer_clear  = (state == IDLE) || (state == DONE);
    assign timer_enable = !timer_clear;

    always_comb begin
        timer_period = STEP_P;
        case (state)
            SETTLE:                timer_period = SETTLE_P;
            game_pkg::EVENT_DWELL: timer_period = DWELL_P;
            default:               timer_period = STEP_P;
        endcase
    end

    anim_tick_timer #(
        .WIDTH(32)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .period (timer_period),
        .tc     (timer_tc)
    );

    always_comb begin
        state_d       = state;
        disp_p1_d     = disp_p1;
        disp_p2_d     = disp_p2;
        active_d      = active_player;
        turn_done_d   = 1'b0;
        step_strobe_d = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    active_d = turn;
                    state_d  = MOVE;
                end else if (active_player) begin
                    disp_p1_d = tgt_p1;
                end else begin
                    disp_p2_d = tgt_p2;
                end
            end

            MOVE: begin
                if (timer_tc) begin
                    if (step_disp != mover_disp) begin
                        step_strobe_d = 1'b1;
                        if (active_player) disp_p2_d = step_disp;
                        else               disp_p1_d = step_disp;
                    end
                    if (step_disp == mover_tgt) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                turn_done_d = 1'b1;
                state_d     = SETTLE;
            end

            SETTLE: begin
                if (timer_tc) begin
                    case (event_flag)
                        4'd0, EV_NONE, EV_WIN: state_d = IDLE;
                        EV_BACK: state_d = (mover_disp != mover_tgt) ? EVENT_MOVE
                                                                     : game_pkg::EVENT_DWELL;
                        4'd2, 4'd4, 4'd6, 4'd8: state_d = game_pkg::EVENT_DWELL;
                        default: state_d = IDLE;
                    endcase
                end
            end

            EVENT_MOVE: begin
                if (timer_tc) begin
                    if (step_disp != mover_disp) begin
                        step_strobe_d = 1'b1;
                        if (active_player) disp_p2_d = step_disp;
                        else               disp_p1_d = step_disp;
                    end
                    if (step_disp == mover_tgt) begin
                        turn_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            game_pkg::EVENT_DWELL: begin
                if (timer_tc) begin
                    turn_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pos_valid_q   <= 1'b0;
            disp_p1       <= 4'd0;
            disp_p2       <= 4'd0;
            active_player <= 1'b0;
            turn_done     <= 1'b0;
            step_strobe   <= 1'b0;
            anim_busy     <= 1'b0;
        end else begin
            state         <= state_d;
            pos_valid_q   <= pos_valid;
            disp_p1       <= disp_p1_d;
            disp_p2       <= disp_p2_d;
            active_player <= active_d;
            turn_done     <= turn_done_d;
            step_strobe   <= step_strobe_d;
            anim_busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_board_token_animator.sv
// Randomised job-level bench for board_token_animator: a timing model predicts
// every step_strobe / turn_done event, which a monitor pops and compares.
module tb_board_token_animator;

    localparam int W = 43;

    logic       clk = 1'b0;
    logic       reset;
    logic       pos_valid;
    logic       turn;
    logic [3:0] p1_pos, p2_pos, event_flag;
    logic       turn_done, active_player, anim_busy, step_strobe;
    logic [3:0] disp_p1, disp_p2;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int disp_m[2];

    logic [W-1:0] exp_q[$];

    board_token_animator #(
        .STEP_CYC    (4),
        .EVENT_DWELL (8),
        .SETTLE_CYC  (4),
        .MAX_POS     (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pos_valid     (pos_valid),
        .turn          (turn),
        .p1_pos        (p1_pos),
        .p2_pos        (p2_pos),
        .event_flag    (event_flag),
        .turn_done     (turn_done),
        .disp_p1       (disp_p1),
        .disp_p2       (disp_p2),
        .active_player (active_player),
        .anim_busy     (anim_busy),
        .step_strobe   (step_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack(input logic [31:0] c, input logic td, input logic ss,
                                          input logic [3:0] d1, input logic [3:0] d2, input logic ap);
        return {c, td, ss, d1, d2, ap};
    endfunction

    function automatic int clampi(input int v);
        return (v > 10) ? 10 : v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every visible strobe or done pulse must match the next prediction.
    always @(negedge clk) begin
        logic [W-1:0] obs;
        if (reset === 1'b0 && (turn_done === 1'b1 || step_strobe === 1'b1)) begin
            obs = pack(32'(cyc), turn_done, step_strobe, disp_p1, disp_p2, active_player);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got %h expected none", obs);
            end else begin
                check("event", obs, exp_q.pop_front());
            end
        end
    end

    // Walk the mover from d[t] to tgt, one event every 4 cycles starting at base+4.
    task automatic walk(input bit t, input int tgt, input int base, input bit done_on_last,
                        inout int d0, inout int d1, output int steps);
        int sgn;
        int cur;
        cur   = t ? d1 : d0;
        steps = (tgt > cur) ? tgt - cur : cur - tgt;
        sgn   = (tgt > cur) ? 1 : -1;
        for (int k = 1; k <= steps; k++) begin
            if (t) d1 += sgn; else d0 += sgn;
            exp_q.push_back(pack(32'(base + 4 * k), done_on_last && (k == steps), 1'b1,
                                 4'(d0), 4'(d1), t));
        end
    endtask

    task automatic run_job(input bit t, input int a, input int b, input int ev,
                           input int back, input int hold);
        int n, t_done, t_end, steps, d0, d1;
        @(negedge clk);
        turn = t; p1_pos = 4'(a); p2_pos = 4'(b); event_flag = 4'(ev); pos_valid = 1'b1;
        n  = cyc;
        d0 = disp_m[0];
        d1 = disp_m[1];
        walk(t, clampi(t ? b : a), n + 1, 1'b0, d0, d1, steps);
        t_done = n + 2 + 4 * ((steps > 0) ? steps : 1);
        exp_q.push_back(pack(32'(t_done), 1'b1, 1'b0, 4'(d0), 4'(d1), t));
        t_end = t_done + 4;
        if (ev == 3) begin
            walk(t, clampi(back), t_end, 1'b1, d0, d1, steps);
            if (steps > 0) begin
                t_end += 4 * steps;
            end else begin
                t_end += 8;
                exp_q.push_back(pack(32'(t_end), 1'b1, 1'b0, 4'(d0), 4'(d1), t));
            end
        end else if (ev == 2 || ev == 4 || ev == 6 || ev == 8) begin
            t_end += 8;
            exp_q.push_back(pack(32'(t_end), 1'b1, 1'b0, 4'(d0), 4'(d1), t));
        end
        if (ev == 3) begin
            while (cyc < t_done + 1) @(negedge clk);
            if (t) p2_pos = 4'(back); else p1_pos = 4'(back);
        end
        while (cyc < t_end + 3 + hold) @(negedge clk);
        // Back in idle the other player's token jumps to its committed square.
        if (t) d0 = clampi(a); else d1 = clampi(b);
        disp_m[0] = d0;
        disp_m[1] = d1;
        check("idle_busy", W'(anim_busy), W'(0));
        check("idle_disp_p1", W'(disp_p1), W'(d0));
        check("idle_disp_p2", W'(disp_p2), W'(d1));
        check("idle_active", W'(active_player), W'(t));
        check("events_drained", W'(exp_q.size()), W'(0));
        pos_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ev_tab[11];
        int n, tgt;
        ev_tab = '{1, 10, 0, 3, 3, 2, 4, 6, 8, 5, 13};
        disp_m[0] = 0;
        disp_m[1] = 0;
        reset = 1'b1; pos_valid = 1'b0; turn = 1'b0;
        p1_pos = 4'd0; p2_pos = 4'd0; event_flag = 4'd1;
        repeat (3) @(negedge clk);
        check("rst_turn_done", W'(turn_done), W'(0));
        check("rst_step_strobe", W'(step_strobe), W'(0));
        check("rst_disp_p1", W'(disp_p1), W'(0));
        check("rst_disp_p2", W'(disp_p2), W'(0));
        check("rst_active", W'(active_player), W'(0));
        check("rst_busy", W'(anim_busy), W'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_job(1'b0, 3, 0, 1, 0, 0);     // P1 0->3, no event
        run_job(1'b0, 3, 5, 1, 0, 0);     // zero-length move; P2 snaps to 5
        run_job(1'b1, 3, 7, 3, 0, 0);     // P2 5->7 then back to 0
        run_job(1'b0, 1, 0, 1, 0, 0);     // P1 3->1
        run_job(1'b0, 4, 0, 4, 0, 0);     // P1 1->4 then dwell
        run_job(1'b0, 9, 0, 1, 0, 0);
        run_job(1'b0, 12, 0, 10, 0, 0);   // clamp at 10, win: no extra pulse
        run_job(1'b1, 10, 0, 1, 0, 50);   // pos_valid held high well past the job

        for (int i = 0; i < 25; i++) begin
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                    ev_tab[$urandom_range(0, 10)],
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
                    $urandom_range(0, 5));
        end

        // Reset in the middle of a P1 walk of at least five squares.
        @(negedge clk);
        tgt = (disp_m[0] >= 5) ? 0 : 10;
        turn = 1'b0; p1_pos = 4'(tgt); event_flag = 4'd1; pos_valid = 1'b1;
        n = cyc;
        exp_q.push_back(pack(32'(n + 5), 1'b0, 1'b1,
                             4'(disp_m[0] + ((tgt > disp_m[0]) ? 1 : -1)), 4'(disp_m[1]), 1'b0));
        while (cyc < n + 7) @(negedge clk);
        check("pre_reset_busy", W'(anim_busy), W'(1));
        check("pre_reset_drained", W'(exp_q.size()), W'(0));
        reset = 1'b1;
        pos_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs",
              W'({turn_done, step_strobe, disp_p1, disp_p2, active_player, anim_busy}), W'(0));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy", W'(anim_busy), W'(0));
        check("post_rst_disp_p1", W'(disp_p1), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
